ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 216 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU, data-RAM request issue with store strobe/data formatting, EX->MEM register.
// One cycle to MEM; memory ops stall until the RAM accepts the address, MEM backpressure holds the entry.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_AW
`define REG_AW 5
`endif
`ifndef MEM_OP_WIDTH
`define MEM_OP_WIDTH 3
`endif
`ifndef MEM_OP_BYTE
`define MEM_OP_BYTE 0
`endif
`ifndef MEM_OP_HALF
`define MEM_OP_HALF 1
`endif
`ifndef MEM_OP_WORD
`define MEM_OP_WORD 2
`endif

module ex_stage (
  input  logic                     clk,
  input  logic                     rst_b,
  // ID -> EX
  output logic                     ex_pipe_ready,
  output logic                     ex_pipe_flush,
  input  logic                     ex_pipe_valid,
  input  logic [`XLEN-1:0]         ex_pipe_pc,
  input  logic [`XLEN-1:0]         ex_pipe_instruction,
  input  logic [3:0]               ex_pipe_alu_op,
  input  logic [`XLEN-1:0]         ex_pipe_src1,
  input  logic [`XLEN-1:0]         ex_pipe_src2,
  input  logic [`XLEN-1:0]         ex_pipe_store_data,
  input  logic                     ex_pipe_mem_read,
  input  logic                     ex_pipe_mem_write,
  input  logic [`MEM_OP_WIDTH-1:0] ex_pipe_mem_opcode,
  input  logic                     ex_pipe_unsign,
  input  logic                     ex_pipe_rd_write,
  input  logic [`REG_AW-1:0]       ex_pipe_rd_addr,
  // EX -> MEM
  input  logic                     mem_pipe_ready,
  input  logic                     mem_pipe_flush,
  output logic                     mem_pipe_valid,
  output logic [`XLEN-1:0]         mem_pipe_pc,
  output logic [`XLEN-1:0]         mem_pipe_instruction,
  output logic [`XLEN-1:0]         mem_pipe_alu_result,
  output logic                     mem_pipe_mem_read,
  output logic                     mem_pipe_unsign,
  output logic                     mem_pipe_rd_write,
  output logic [`MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
  output logic [1:0]               mem_pipe_mem_byte_addr,
  output logic [`REG_AW-1:0]       mem_pipe_rd_addr,
  // hazard info to ID
  output logic                     ex_rd_write,
  output logic                     ex_mem_read,
  output logic [`REG_AW-1:0]       ex_rd_addr,
  output logic [`XLEN-1:0]         ex_rd_wdata,
  // data RAM request
  output logic                     dram_req,
  output logic                     dram_write,
  output logic [`XLEN-1:0]         dram_addr,
  output logic [`XLEN-1:0]         dram_wdata,
  output logic [3:0]               dram_wstrb,
  input  logic                     dram_addr_ok
);

  localparam int XW = `XLEN;
  localparam int AW = `REG_AW;
  localparam int OW = `MEM_OP_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;

  logic          ex_valid;
  logic          is_mem;
  logic          ex_done;
  logic          ex_fwd;
  logic          req_accepted;
  logic [XW-1:0] alu_result;
  logic [4:0]    shamt;
  logic [1:0]    byte_addr;

  logic          req_sent_q, req_sent_d;
  logic          started_q;
  logic          mem_valid_q, mem_valid_d;
  logic          load_payload;

  logic [XW-1:0] pc_q, instr_q, result_q;
  logic          mem_read_q, unsign_q, rd_write_q;
  logic [OW-1:0] mem_op_q;
  logic [AW-1:0] rd_addr_q;

  // ---------------------------------------------------------------- ALU
  assign shamt = ex_pipe_src2[4:0];

  always_comb begin
    alu_result = '0;
    unique case (ex_pipe_alu_op)
      OP_ADD:  alu_result = ex_pipe_src1 + ex_pipe_src2;
      OP_SUB:  alu_result = ex_pipe_src1 - ex_pipe_src2;
      OP_AND:  alu_result = ex_pipe_src1 & ex_pipe_src2;
      OP_OR:   alu_result = ex_pipe_src1 | ex_pipe_src2;
      OP_XOR:  alu_result = ex_pipe_src1 ^ ex_pipe_src2;
      OP_SLL:  alu_result = ex_pipe_src1 << shamt;
      OP_SRL:  alu_result = ex_pipe_src1 >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(ex_pipe_src1) >>> shamt);
      OP_SLT:  alu_result = {{(XW-1){1'b0}}, $signed(ex_pipe_src1) < $signed(ex_pipe_src2)};
      OP_SLTU: alu_result = {{(XW-1){1'b0}}, ex_pipe_src1 < ex_pipe_src2};
      OP_PASS: alu_result = ex_pipe_src2;
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------- handshake
  assign ex_valid      = ex_pipe_valid & ~mem_pipe_flush;
  assign ex_pipe_flush = mem_pipe_flush;
  assign is_mem        = ex_pipe_mem_read | ex_pipe_mem_write;

  // started_q keeps the RAM quiet on the first cycle out of reset.
  assign dram_req      = rst_b & started_q & ex_valid & is_mem & ~req_sent_q;
  assign req_accepted  = dram_req & dram_addr_ok;
  assign ex_done       = ~is_mem | req_sent_q | req_accepted;
  assign ex_fwd        = ex_valid & ex_done;
  assign ex_pipe_ready = ~ex_valid | (ex_fwd & mem_pipe_ready);
  assign load_payload  = mem_pipe_ready & ex_fwd;

  always_comb begin
    req_sent_d = req_sent_q;
    if (mem_pipe_flush || ex_pipe_ready) begin
      req_sent_d = 1'b0;
    end else if (req_accepted) begin
      req_sent_d = 1'b1;
    end
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    if (mem_pipe_ready) begin
      mem_valid_d = ex_fwd;
    end
  end

  // ---------------------------------------------------------------- RAM request
  assign byte_addr  = alu_result[1:0];
  assign dram_write = ex_pipe_mem_write;
  assign dram_addr  = alu_result;

  always_comb begin
    dram_wstrb = 4'b0000;
    dram_wdata = ex_pipe_store_data;
    if (ex_pipe_mem_opcode[`MEM_OP_BYTE]) begin
      dram_wstrb = 4'b0001 << byte_addr;
      dram_wdata = {4{ex_pipe_store_data[7:0]}};
    end else if (ex_pipe_mem_opcode[`MEM_OP_HALF]) begin
      dram_wstrb = byte_addr[1] ? 4'b1100 : 4'b0011;
      dram_wdata = {2{ex_pipe_store_data[15:0]}};
    end else if (ex_pipe_mem_opcode[`MEM_OP_WORD]) begin
      dram_wstrb = 4'b1111;
    end
  end

  // ---------------------------------------------------------------- hazard info
  assign ex_rd_write = ex_pipe_valid & ex_pipe_rd_write;
  assign ex_rd_addr  = ex_pipe_rd_addr;
  assign ex_rd_wdata = alu_result;
  assign ex_mem_read = ex_pipe_valid & ex_pipe_mem_read;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      mem_valid_q <= 1'b0;
      req_sent_q  <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      req_sent_q  <= req_sent_d;
      started_q   <= 1'b1;
    end
  end

  // Payload carries no reset; it is only meaningful while mem_pipe_valid is set.
  always_ff @(posedge clk) begin
    if (load_payload) begin
      pc_q       <= ex_pipe_pc;
      instr_q    <= ex_pipe_instruction;
      result_q   <= alu_result;
      mem_read_q <= ex_pipe_mem_read;
      unsign_q   <= ex_pipe_unsign;
      rd_write_q <= ex_pipe_rd_write;
      mem_op_q   <= ex_pipe_mem_opcode;
      rd_addr_q  <= ex_pipe_rd_addr;
    end
  end

  assign mem_pipe_valid         = mem_valid_q;
  assign mem_pipe_pc            = pc_q;
  assign mem_pipe_instruction   = instr_q;
  assign mem_pipe_alu_result    = result_q;
  assign mem_pipe_mem_read      = mem_read_q;
  assign mem_pipe_unsign        = unsign_q;
  assign mem_pipe_rd_write      = rd_write_q;
  assign mem_pipe_mem_opcode    = mem_op_q;
  assign mem_pipe_mem_byte_addr = result_q[1:0];
  assign mem_pipe_rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomised and directed checks of ex_stage against a cycle-level behavioural reference.
module tb_ex_stage;

  logic        clk;
  logic        rst_b;
  logic        ex_pipe_ready, ex_pipe_flush, ex_pipe_valid;
  logic [31:0] ex_pipe_pc, ex_pipe_instruction, ex_pipe_src1, ex_pipe_src2, ex_pipe_store_data;
  logic [3:0]  ex_pipe_alu_op;
  logic        ex_pipe_mem_read, ex_pipe_mem_write, ex_pipe_unsign, ex_pipe_rd_write;
  logic [2:0]  ex_pipe_mem_opcode;
  logic [4:0]  ex_pipe_rd_addr;
  logic        mem_pipe_ready, mem_pipe_flush, mem_pipe_valid;
  logic [31:0] mem_pipe_pc, mem_pipe_instruction, mem_pipe_alu_result;
  logic        mem_pipe_mem_read, mem_pipe_unsign, mem_pipe_rd_write;
  logic [2:0]  mem_pipe_mem_opcode;
  logic [1:0]  mem_pipe_mem_byte_addr;
  logic [4:0]  mem_pipe_rd_addr;
  logic        ex_rd_write, ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_rd_wdata;
  logic        dram_req, dram_write, dram_addr_ok;
  logic [31:0] dram_addr, dram_wdata;
  logic [3:0]  dram_wstrb;

  ex_stage dut (
    .clk(clk), .rst_b(rst_b),
    .ex_pipe_ready(ex_pipe_ready), .ex_pipe_flush(ex_pipe_flush), .ex_pipe_valid(ex_pipe_valid),
    .ex_pipe_pc(ex_pipe_pc), .ex_pipe_instruction(ex_pipe_instruction), .ex_pipe_alu_op(ex_pipe_alu_op),
    .ex_pipe_src1(ex_pipe_src1), .ex_pipe_src2(ex_pipe_src2), .ex_pipe_store_data(ex_pipe_store_data),
    .ex_pipe_mem_read(ex_pipe_mem_read), .ex_pipe_mem_write(ex_pipe_mem_write),
    .ex_pipe_mem_opcode(ex_pipe_mem_opcode), .ex_pipe_unsign(ex_pipe_unsign),
    .ex_pipe_rd_write(ex_pipe_rd_write), .ex_pipe_rd_addr(ex_pipe_rd_addr),
    .mem_pipe_ready(mem_pipe_ready), .mem_pipe_flush(mem_pipe_flush), .mem_pipe_valid(mem_pipe_valid),
    .mem_pipe_pc(mem_pipe_pc), .mem_pipe_instruction(mem_pipe_instruction),
    .mem_pipe_alu_result(mem_pipe_alu_result), .mem_pipe_mem_read(mem_pipe_mem_read),
    .mem_pipe_unsign(mem_pipe_unsign), .mem_pipe_rd_write(mem_pipe_rd_write),
    .mem_pipe_mem_opcode(mem_pipe_mem_opcode), .mem_pipe_mem_byte_addr(mem_pipe_mem_byte_addr),
    .mem_pipe_rd_addr(mem_pipe_rd_addr),
    .ex_rd_write(ex_rd_write), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .ex_rd_wdata(ex_rd_wdata),
    .dram_req(dram_req), .dram_write(dram_write), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_wstrb(dram_wstrb), .dram_addr_ok(dram_addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;

  // reference model state
  logic        m_vld, m_sent, m_started, m_rdy;
  logic [31:0] m_pc, m_ins, m_res;
  logic        m_mrd, m_uns, m_rdw;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    sh = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0:  return a + b;
      1:  return a + (~b + 1);
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return 32'(64'(a) * (64'd1 << sh));
      6:  return 32'(a / (33'd1 << sh));
      7:  return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      8:  return (sa < sb) ? 32'd1 : 32'd0;
      9:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] strb_ref(input logic [2:0] op, input logic [1:0] a);
    if (op == 3'b001) return 4'(1 << a);
    if (op == 3'b010) return (a >= 2) ? 4'd12 : 4'd3;
    if (op == 3'b100) return 4'd15;
    return 4'd0;
  endfunction

  function automatic logic [31:0] wdata_ref(input logic [2:0] op, input logic [31:0] d);
    if (op == 3'b001) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (op == 3'b010) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    logic ev, ism, dreq, done, fwd, rdy;
    logic [31:0] res;
    #1;
    res  = alu_ref(ex_pipe_alu_op, ex_pipe_src1, ex_pipe_src2);
    ev   = ex_pipe_valid & ~mem_pipe_flush;
    ism  = ex_pipe_mem_read | ex_pipe_mem_write;
    dreq = rst_b & m_started & ev & ism & ~m_sent;
    done = ~ism | m_sent | (dreq & dram_addr_ok);
    fwd  = ev & done;
    rdy  = ~ev | (fwd & mem_pipe_ready);
    m_rdy = rdy;
    chk("ex_pipe_ready", ex_pipe_ready, rdy);
    chk("ex_pipe_flush", ex_pipe_flush, mem_pipe_flush);
    chk("dram_req", dram_req, dreq);
    if (dreq) begin
      chk("dram_addr", dram_addr, res);
      chk("dram_write", dram_write, ex_pipe_mem_write);
      if (ex_pipe_mem_write) begin
        chk("dram_wstrb", dram_wstrb, strb_ref(ex_pipe_mem_opcode, res[1:0]));
        chk("dram_wdata", dram_wdata, wdata_ref(ex_pipe_mem_opcode, ex_pipe_store_data));
      end
    end
    chk("ex_rd_write", ex_rd_write, ex_pipe_valid & ex_pipe_rd_write);
    chk("ex_rd_addr", ex_rd_addr, ex_pipe_rd_addr);
    chk("ex_rd_wdata", ex_rd_wdata, res);
    chk("ex_mem_read", ex_mem_read, ex_pipe_valid & ex_pipe_mem_read);
    if (dram_req && dram_addr_ok) acc_cnt++;
    @(posedge clk);
    if (!rst_b) begin
      m_vld = 0; m_sent = 0; m_started = 0;
    end else begin
      m_started = 1;
      if (mem_pipe_ready) m_vld = fwd;
      if (mem_pipe_ready && fwd) begin
        m_pc = ex_pipe_pc; m_ins = ex_pipe_instruction; m_res = res;
        m_mrd = ex_pipe_mem_read; m_uns = ex_pipe_unsign; m_rdw = ex_pipe_rd_write;
        m_op = ex_pipe_mem_opcode; m_rd = ex_pipe_rd_addr;
      end
      if (mem_pipe_flush || rdy) m_sent = 0;
      else if (dreq && dram_addr_ok) m_sent = 1;
    end
    #1;
    chk("mem_pipe_valid", mem_pipe_valid, m_vld);
    if (m_vld) begin
      chk("mem_pc", mem_pipe_pc, m_pc);
      chk("mem_instr", mem_pipe_instruction, m_ins);
      chk("mem_result", mem_pipe_alu_result, m_res);
      chk("mem_byte_addr", mem_pipe_mem_byte_addr, m_res[1:0]);
      chk("mem_ctrl", {mem_pipe_mem_read, mem_pipe_unsign, mem_pipe_rd_write, mem_pipe_mem_opcode},
          {m_mrd, m_uns, m_rdw, m_op});
      chk("mem_rd_addr", mem_pipe_rd_addr, m_rd);
    end
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic rd_, input logic wr_, input logic [2:0] mop, input logic [31:0] sd);
    ex_pipe_valid = 1; ex_pipe_alu_op = op; ex_pipe_src1 = a; ex_pipe_src2 = b;
    ex_pipe_mem_read = rd_; ex_pipe_mem_write = wr_; ex_pipe_mem_opcode = mop; ex_pipe_store_data = sd;
    ex_pipe_pc = $urandom; ex_pipe_instruction = $urandom; ex_pipe_unsign = 1'($urandom);
    ex_pipe_rd_write = ~wr_; ex_pipe_rd_addr = 5'($urandom);
  endtask

  task automatic rand_instr();
    int k;
    logic [2:0] mop;
    k = $urandom_range(0, 3);
    mop = 3'b001 << $urandom_range(0, 2);
    if (k == 0)      set_instr(4'd0, $urandom_range(0, 4095), $urandom_range(0, 255), 1, 0, mop, $urandom);
    else if (k == 1) set_instr(4'd0, $urandom_range(0, 4095), $urandom_range(0, 255), 0, 1, mop, $urandom);
    else             set_instr(4'($urandom_range(0, 15)), $urandom, $urandom, 0, 0, mop, $urandom);
    ex_pipe_valid = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    m_vld = 0; m_sent = 0; m_started = 0; m_rdy = 1;
    m_pc = 0; m_ins = 0; m_res = 0; m_mrd = 0; m_uns = 0; m_rdw = 0; m_op = 0; m_rd = 0;
    rst_b = 0; mem_pipe_ready = 1; mem_pipe_flush = 0; dram_addr_ok = 1;
    // a pending load during reset must not reach the RAM
    set_instr(4'd0, 32'h100, 32'h4, 1, 0, 3'b100, 32'h0);
    tick(); tick();
    chk("reset_valid", mem_pipe_valid, 0);
    rst_b = 1;
    tick();                                   // first cycle out of reset: no request
    tick();                                   // load now issues and advances

    // ADD wrap-around
    set_instr(4'd0, 32'hFFFF_FFFF, 32'd1, 0, 0, 3'b100, 32'h0);
    tick();
    chk("add_wrap_vld", mem_pipe_valid, 1);
    chk("add_wrap_res", mem_pipe_alu_result, 32'h0000_0000);
    set_instr(4'd7, 32'h8000_0000, 32'd4, 0, 0, 3'b100, 0); tick();
    chk("sra", ex_rd_wdata, 32'hF800_0000);
    set_instr(4'd8, 32'hFFFF_FFFF, 32'd1, 0, 0, 3'b100, 0); tick();
    chk("slt", ex_rd_wdata, 32'd1);
    set_instr(4'd9, 32'hFFFF_FFFF, 32'd1, 0, 0, 3'b100, 0); tick();
    chk("sltu", ex_rd_wdata, 32'd0);

    // byte store at 0x1003
    set_instr(4'd0, 32'h1000, 32'd3, 0, 1, 3'b001, 32'h0000_00AB); tick();
    chk("sb_wstrb", dram_wstrb, 4'b1000);
    chk("sb_wdata", dram_wdata, 32'hABAB_ABAB);

    // load held off by the RAM for three cycles
    ex_pipe_valid = 0; tick();
    set_instr(4'd0, 32'h2000, 32'd8, 1, 0, 3'b100, 0);
    dram_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req", dram_req, 1);
      chk("stall_ready", ex_pipe_ready, 0);
      chk("stall_vld", mem_pipe_valid, 0);
    end
    dram_addr_ok = 1; tick();
    chk("stall_adv", mem_pipe_valid, 1);

    // accepted while MEM is stalled: one request only
    set_instr(4'd0, 32'h3000, 32'd4, 1, 0, 3'b100, 0);
    mem_pipe_ready = 0; acc_cnt = 0;
    tick(); tick();
    mem_pipe_ready = 1; tick();
    chk("one_req", acc_cnt, 1);
    chk("one_req_adv", mem_pipe_valid, 1);

    // flush with a pending load
    set_instr(4'd0, 32'h4000, 32'd0, 1, 0, 3'b100, 0);
    dram_addr_ok = 0; mem_pipe_flush = 1; tick();
    chk("flush_req", dram_req, 0);
    chk("flush_ready", ex_pipe_ready, 1);
    chk("flush_vld", mem_pipe_valid, 0);
    mem_pipe_flush = 0;

    // randomised traffic
    for (int c = 0; c < 2000; c++) begin
      if (m_rdy) rand_instr();
      dram_addr_ok   = ($urandom_range(0, 1) == 1);
      mem_pipe_ready = ($urandom_range(0, 9) < 7);
      mem_pipe_flush = ($urandom_range(0, 9) == 0);
      if (c == 1000) rst_b = 0;
      if (c == 1003) rst_b = 1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
